hamming_frame_ctrl: RTL
=======================

// Module: hamming_frame_ctrl
// PURPOSE
//  Single-clock sequencer for the 15/11 Hamming receive datapath (15-bit input shift reg ->
//  combinational decoder -> 11-bit output shift reg). Counts incoming code bits, aligns frames on
//  frame_sync, and pulses the decoder-output load. Streams 11 data bits out under a valid/ready
//  handshake. Replaces the free-running two-clock counter scheme; flags overrun and corrections.
// PARAMETERS
//  N_CODE    15  code bits per frame (input shift length)
//  K_DATA    11  data bits per frame (output shift length)
//  SYN_W      4  decoder syndrome width
//  ERRCNT_W  16  corrected-frame counter width (ERR_CNT_EN only)
// PORTS
//  clk        in   1         single clock, rising edge
//  reset      in   1         asynchronous, active-low reset
//  in_valid   in   1         serial code bit present this cycle
//  frame_sync in   1         qualified by in_valid: this bit is code bit 0 of a new frame
//  in_shift   out  1         shift enable to input shift register (= in_valid, combinational)
//  syndrome   in   SYN_W     decoder syndrome of current input register contents
//  dec_load   out  1         1-cycle pulse: write decoder output into output shift register
//  corrected  out  1         1-cycle pulse with dec_load when syndrome != 0
//  out_shift  out  1         shift enable to output shift register
//  out_valid  out  1         s_out bit is valid
//  out_ready  in   1         downstream accepts the s_out bit
//  out_last   out  1         current out bit is data bit K_DATA-1
//  busy       out  1         frame in reception (rx_cnt != 0) or TX in SHIFT
//  overrun    out  1         sticky: completed frame dropped because TX was busy
//  err_clr    in   1         synchronous clear of overrun (and err_count)
//  err_count  out  ERRCNT_W  saturating count of corrected frames (ERR_CNT_EN only)
// BEHAVIOUR
//  Reset: rx_cnt=0, rx_done_q=0, TX=IDLE, tx_cnt=0, overrun=0, err_count=0; all registered outputs 0.
//  RX: on in_valid: frame_sync -> rx_cnt<=1; else rx_cnt==N_CODE-1 -> rx_cnt<=0, rx_done_q<=1;
//   else rx_cnt<=rx_cnt+1. rx_done_q is a 1-cycle pulse. frame_sync mid-frame discards partial frame.
//  Load: in the cycle rx_done_q=1 (input reg holds 15 bits, syndrome valid):
//   TX IDLE, or TX SHIFT with out_last&&out_ready -> dec_load=1, corrected=(syndrome!=0).
//   Otherwise frame dropped, dec_load=0, overrun<=1. Latency: last code bit edge -> dec_load 1 cycle.
//  in_valid in the dec_load cycle is legal; the register write samples pre-edge contents.
//  TX FSM: IDLE --dec_load--> SHIFT (tx_cnt<=0). SHIFT: out_valid=1; out_valid&&out_ready ->
//   out_shift=1, tx_cnt++; at tx_cnt==K_DATA-1 (out_last=1) handshake -> IDLE, or SHIFT with
//   tx_cnt<=0 if dec_load same cycle. dec_load has priority: out_shift forced 0 when dec_load=1.
//  out_valid low -> out_shift=0; out_ready ignored in IDLE. Bit order is output register shift order.
//  err_clr and overrun-set in the same cycle: set wins. Reset mid-frame: partial RX/TX discarded.
//  Counters 4-bit (clog2(N_CODE)); no wrap beyond N_CODE-1 / K_DATA-1.
// CONFIGURATION
//  ERR_CNT_EN defined: err_count port present. Increments on corrected=1, saturates at all-ones,
//   clears on err_clr (increment in same cycle loses).
//  ERR_CNT_EN undefined: err_count port and its logic absent; corrected pulse unchanged.
// STRUCTURE
//  Package hamming_pkg: N_CODE, K_DATA, SYN_W constants; CNT_W = $clog2(N_CODE);
//   tx_state_t {TX_IDLE, TX_SHIFT}.
//  One sub-module: frame_bit_counter (mod-N up counter with sync load), instanced for RX and TX.
// TESTING
//  1. frame_sync + 15 in_valid bits, out_ready=1, syndrome=0 -> dec_load one cycle after 15th bit,
//     corrected=0, 11 out_valid cycles, out_last on 11th, busy drops after.
//  2. Same frame with syndrome=4'h5 -> corrected=1 with dec_load; err_count 0->1 (ERR_CNT_EN).
//  3. out_ready low for 20 cycles while next 15 bits arrive -> frame dropped, overrun=1, no
//     dec_load; err_clr -> overrun=0.
//  4. out_ready toggling; new frame completes on cycle of last-bit handshake -> dec_load=1,
//     out_shift=0, TX restarts tx_cnt=0, overrun stays 0.
//  5. frame_sync after 7 bits -> rx_cnt=1, dec_load only after 14 further bits.
//  6. reset low mid-TX (tx_cnt=6) -> all outputs 0 asynchronously, TX_IDLE after release.

Source files
------------

// File: rtl/hamming_frame_ctrl_pkg.sv
// Shared constants and types for the 15/11 Hamming receive sequencer.
package hamming_pkg;

  localparam int N_CODE   = 15;
  localparam int K_DATA   = 11;
  localparam int SYN_W    = 4;
  localparam int ERRCNT_W = 16;
  localparam int CNT_W    = $clog2(N_CODE);

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

endpackage

// File: rtl/hamming_frame_ctrl_if.sv
// Control bundle between the frame sequencer (master) and the shift/decoder datapath (slave).
interface hamming_frame_ctrl_if;
  import hamming_pkg::*;

  logic             in_valid;
  logic             frame_sync;
  logic             in_shift;
  logic [SYN_W-1:0] syndrome;
  logic             dec_load;
  logic             corrected;
  logic             out_shift;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             overrun;
  logic             err_clr;
`ifdef ERR_CNT_EN
  logic [ERRCNT_W-1:0] err_count;
`endif

  modport master (
    input  in_valid, frame_sync, syndrome, out_ready, err_clr,
    output in_shift, dec_load, corrected, out_shift, out_valid, out_last, busy, overrun
`ifdef ERR_CNT_EN
    , output err_count
`endif
  );

  modport slave (
    output in_valid, frame_sync, syndrome, out_ready, err_clr,
    input  in_shift, dec_load, corrected, out_shift, out_valid, out_last, busy, overrun
`ifdef ERR_CNT_EN
    , input err_count
`endif
  );

endinterface

// File: rtl/hamming_frame_ctrl_counter.sv
// Mod-(MAX+1) up counter with synchronous load; load has priority over count.
module frame_bit_counter
  import hamming_pkg::*;
#(
  parameter int W   = CNT_W,
  parameter int MAX = N_CODE - 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  // NOTE: state registers use <= so every flop samples pre-edge values in the same step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (load)   cnt <= load_val;
    else if (en)     cnt <= (cnt == W'(MAX)) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/hamming_frame_ctrl.sv
// Frame sequencer for the 15/11 Hamming RX datapath: aligns frames, loads decoder, streams data.
// Define ERR_CNT_EN to add the saturating corrected-frame counter (err_count).
module hamming_frame_ctrl
  import hamming_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  hamming_frame_ctrl_if.master bus
);

  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] tx_cnt;
  logic             rx_done_q;
  logic             can_load;
  tx_state_t        state, state_nxt;

  assign bus.in_shift = bus.in_valid;

  frame_bit_counter #(.W(CNT_W), .MAX(N_CODE - 1)) u_rx_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.in_valid),
    .load     (bus.in_valid & bus.frame_sync),
    .load_val (CNT_W'(1)),
    .cnt      (rx_cnt)
  );

  frame_bit_counter #(.W(CNT_W), .MAX(K_DATA - 1)) u_tx_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.out_shift),
    .load     (bus.dec_load),
    .load_val ('0),
    .cnt      (tx_cnt)
  );

  // Frame complete: the 15th code bit was accepted without a fresh sync on it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_done_q <= 1'b0;
    else        rx_done_q <= bus.in_valid & ~bus.frame_sync & (rx_cnt == CNT_W'(N_CODE - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= TX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:  if (bus.dec_load) state_nxt = TX_SHIFT;
      TX_SHIFT: if (!bus.dec_load && bus.out_last && bus.out_ready) state_nxt = TX_IDLE;
      default:  state_nxt = TX_IDLE;
    endcase
  end

  // NOTE: every output gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    bus.out_valid = (state == TX_SHIFT);
    bus.out_last  = bus.out_valid && (tx_cnt == CNT_W'(K_DATA - 1));
    can_load      = (state == TX_IDLE) || (bus.out_last && bus.out_ready);
    bus.dec_load  = rx_done_q && can_load;
    bus.corrected = bus.dec_load && (bus.syndrome != '0);
    bus.out_shift = bus.out_valid && bus.out_ready && !bus.dec_load;
    bus.busy      = (rx_cnt != '0) || (state == TX_SHIFT);
  end

  // A drop in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     bus.overrun <= 1'b0;
    else if (rx_done_q && !can_load) bus.overrun <= 1'b1;
    else if (bus.err_clr)           bus.overrun <= 1'b0;
  end

`ifdef ERR_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   bus.err_count <= '0;
    else if (bus.err_clr)                         bus.err_count <= '0;
    else if (bus.corrected && (bus.err_count != '1)) bus.err_count <= bus.err_count + 1'b1;
  end
`endif

endmodule
